// File: rtl/pa_muldiv.sv
// ----------------------------------------------------------------------------
// pa_muldiv -- iterative multiply / divide engine for the P-A datapath.
//
// Takes an operand pair, runs one bit per cycle, and returns either a
// 2*WIDTH product or a quotient/remainder pair together with Z/M/overflow
// flags. Handshake is start/busy/done.
//
// Parameters:
//   WIDTH  - operand width (>= 4, even)
//   DIV_EN - 1: division implemented; 0: div ops finish at once with ovf=1
//
// Ports:
//   clk_sys        system clock
//   clr_           asynchronous active-low reset
//   start          request, accepted only while idle
//   op[1:0]        00 unsigned mul, 01 signed mul, 10 signed div, 11 unsigned div
//   hi             dividend high word (div only)
//   lo             multiplicand (mul) / dividend low word (div)
//   b              multiplier (mul) / divisor (div)
//   busy           operation in progress (held through the done cycle)
//   done           one-cycle pulse, results valid
//   res_hi/res_lo  product high/low word, or remainder/quotient
//   ovf            division overflow or divide-by-zero
//   zf, mf         zero / sign of the result
//
// Optional feature (macro PA_MULDIV_EARLY_EN): multiplications leave the
// iteration phase as soon as the remaining multiplier bits are all zero and
// the accumulator is realigned in the fix-up cycle.
// ----------------------------------------------------------------------------
module pa_muldiv #(
    parameter int WIDTH  = 16,
    parameter int DIV_EN = 1
) (
    input  logic             clk_sys,
    input  logic             clr_,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             ovf,
    output logic             zf,
    output logic             mf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] HALF    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] HALF_M1 = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_FIX, S_DONE} state_t;

    state_t             state_reg,  state_next;
    logic [1:0]         op_reg,     op_next;
    logic [2*WIDTH-1:0] acc_reg,    acc_next;    // {rem/partial, quo/multiplier}
    logic [WIDTH-1:0]   dv_reg,     dv_next;     // multiplicand or divisor magnitude
    logic [CW-1:0]      cnt_reg,    cnt_next;
    logic               rsign_reg,  rsign_next;  // sign of product / quotient
    logic               dsign_reg,  dsign_next;  // sign of remainder (= dividend)
    logic [WIDTH-1:0]   res_hi_reg, res_hi_next;
    logic [WIDTH-1:0]   res_lo_reg, res_lo_next;
    logic               ovf_reg,    ovf_next;
    logic               zf_reg,     zf_next;
    logic               mf_reg,     mf_next;

    // Before PRE, acc holds the raw {hi, lo} and dv holds the raw b.
    logic               is_div, is_signed;
    logic               dvd_neg, lo_neg, b_neg;
    logic [2*WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0]   lo_mag, b_mag;

    assign is_div    = op_reg[1];
    assign is_signed = op_reg[1] ^ op_reg[0];
    assign dvd_neg   = is_signed & acc_reg[2*WIDTH-1];
    assign lo_neg    = is_signed & acc_reg[WIDTH-1];
    assign b_neg     = is_signed & dv_reg[WIDTH-1];
    assign dvd_mag   = dvd_neg ? -acc_reg : acc_reg;
    assign lo_mag    = lo_neg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign b_mag     = b_neg ? -dv_reg : dv_reg;

    // One multiply step: conditional add into the high half, then shift right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, dv_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // One restoring-divide step. The partial remainder stays below the
    // divisor, so the shifted value needs only one extra bit.
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_nb;
    logic [2*WIDTH-1:0] div_step;
    assign div_sh   = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, dv_reg};
    assign div_nb   = ~div_diff[WIDTH];
    assign div_step = {(div_nb ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                       acc_reg[WIDTH-2:0], div_nb};

    // Fix-up: sign restoration and signed quotient range check.
    logic [2*WIDTH-1:0] prod_mag, fix_prod;
    logic [WIDTH-1:0]   quo_mag, rem_mag, fix_quo, fix_rem;
    logic               fix_ovf;
`ifdef PA_MULDIV_EARLY_EN
    // cnt_reg holds the number of shifts skipped by the early exit.
    assign prod_mag = acc_reg >> cnt_reg;
`else
    assign prod_mag = acc_reg;
`endif
    assign fix_prod = rsign_reg ? -prod_mag : prod_mag;
    assign quo_mag  = acc_reg[WIDTH-1:0];
    assign rem_mag  = acc_reg[2*WIDTH-1:WIDTH];
    assign fix_quo  = rsign_reg ? -quo_mag : quo_mag;
    assign fix_rem  = dsign_reg ? -rem_mag : rem_mag;
    assign fix_ovf  = is_signed & (quo_mag > (rsign_reg ? HALF : HALF_M1));

`ifdef PA_MULDIV_EARLY_EN
    // After the step at count c, the unprocessed multiplier bits sit in
    // the low c bits of the accumulator.
    logic [WIDTH-1:0] rem_mask;
    assign rem_mask = ~({WIDTH{1'b1}} << cnt_reg);
`endif

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        acc_next    = acc_reg;
        dv_next     = dv_reg;
        cnt_next    = cnt_reg;
        rsign_next  = rsign_reg;
        dsign_next  = dsign_reg;
        res_hi_next = res_hi_reg;
        res_lo_next = res_lo_reg;
        ovf_next    = ovf_reg;
        zf_next     = zf_reg;
        mf_next     = mf_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    op_next    = op;
                    acc_next   = {hi, lo};
                    dv_next    = b;
                    state_next = S_PRE;
                end
            end
            S_PRE: begin
                cnt_next = CW'(WIDTH - 1);
                if (is_div) begin
                    acc_next   = dvd_mag;
                    dv_next    = b_mag;
                    rsign_next = dvd_neg ^ b_neg;
                    dsign_next = dvd_neg;
                    // A high word at or above the divisor cannot yield a
                    // WIDTH-bit quotient; this also covers b == 0.
                    if (DIV_EN == 0 || b_mag == '0
                        || dvd_mag[2*WIDTH-1:WIDTH] >= b_mag) begin
                        ovf_next   = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ITER;
                    end
                end else begin
                    acc_next   = {{WIDTH{1'b0}}, b_mag};
                    dv_next    = lo_mag;
                    rsign_next = lo_neg ^ b_neg;
                    dsign_next = 1'b0;
                    state_next = S_ITER;
`ifdef PA_MULDIV_EARLY_EN
                    if (b_mag == '0) begin
                        state_next = S_FIX;
                    end
`endif
                end
            end
            S_ITER: begin
                acc_next = is_div ? div_step : mul_step;
                if (cnt_reg == '0) begin
                    state_next = S_FIX;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
`ifdef PA_MULDIV_EARLY_EN
                if (!is_div && (mul_step[WIDTH-1:0] & rem_mask) == '0) begin
                    state_next = S_FIX;
                    cnt_next   = cnt_reg;
                end
`endif
            end
            S_FIX: begin
                state_next = S_DONE;
                if (is_div) begin
                    if (fix_ovf) begin
                        ovf_next = 1'b1;
                    end else begin
                        res_hi_next = fix_rem;
                        res_lo_next = fix_quo;
                        zf_next     = (fix_quo == '0);
                        mf_next     = fix_quo[WIDTH-1];
                        ovf_next    = 1'b0;
                    end
                end else begin
                    res_hi_next = fix_prod[2*WIDTH-1:WIDTH];
                    res_lo_next = fix_prod[WIDTH-1:0];
                    zf_next     = (fix_prod == '0);
                    mf_next     = fix_prod[2*WIDTH-1];
                    ovf_next    = 1'b0;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge clr_) begin
        if (!clr_) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            acc_reg    <= '0;
            dv_reg     <= '0;
            cnt_reg    <= '0;
            rsign_reg  <= 1'b0;
            dsign_reg  <= 1'b0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
            ovf_reg    <= 1'b0;
            zf_reg     <= 1'b0;
            mf_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            acc_reg    <= acc_next;
            dv_reg     <= dv_next;
            cnt_reg    <= cnt_next;
            rsign_reg  <= rsign_next;
            dsign_reg  <= dsign_next;
            res_hi_reg <= res_hi_next;
            res_lo_reg <= res_lo_next;
            ovf_reg    <= ovf_next;
            zf_reg     <= zf_next;
            mf_reg     <= mf_next;
        end
    end

    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_DONE);
    assign res_hi = res_hi_reg;
    assign res_lo = res_lo_reg;
    assign ovf    = ovf_reg;
    assign zf     = zf_reg;
    assign mf     = mf_reg;
endmodule

// File: tb/tb_pa_muldiv.sv
// ----------------------------------------------------------------------------
// tb_pa_muldiv -- directed bench for pa_muldiv at WIDTH=16.
// Each step launches one operation and checks latency, results and flags
// against hand-computed values. Honours PA_MULDIV_EARLY_EN when defined.
// ----------------------------------------------------------------------------
module tb_pa_muldiv;
    localparam int W = 16;
`ifdef PA_MULDIV_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk_sys = 1'b0;
    logic         clr_    = 1'b0;
    logic         start   = 1'b0;
    logic [1:0]   op      = 2'b00;
    logic [W-1:0] hi      = '0;
    logic [W-1:0] lo      = '0;
    logic [W-1:0] b       = '0;
    logic         busy, done, ovf, zf, mf;
    logic [W-1:0] res_hi, res_lo;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    pa_muldiv #(.WIDTH(W), .DIV_EN(1)) dut (
        .clk_sys(clk_sys), .clr_(clr_), .start(start), .op(op),
        .hi(hi), .lo(lo), .b(b), .busy(busy), .done(done),
        .res_hi(res_hi), .res_lo(res_lo), .ovf(ovf), .zf(zf), .mf(mf)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Launch an op so that start is sampled at edge k, then wait for done.
    // lat = cycle offset (after edge k) in which done is seen. If poke >= 0,
    // start is raised with other operands at the negedge of cycle k+poke,
    // i.e. sampled at edge k+poke+1.
    task automatic run(input logic [1:0] o, input logic [W-1:0] h,
                       input logic [W-1:0] l, input logic [W-1:0] bb, input int poke);
        @(negedge clk_sys);
        op = o; hi = h; lo = l; b = bb; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 60) begin
            if (lat == poke) begin
                start = 1'b1; op = 2'b00; lo = 16'hFFFF; b = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_sys);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic expect_res(input string tag, input int elat, input logic eovf,
                              input logic [W-1:0] ehi, input logic [W-1:0] elo,
                              input logic ezf, input logic emf);
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eovf});
        chk({tag, ".res_hi"}, {16'd0, res_hi}, {16'd0, ehi});
        chk({tag, ".res_lo"}, {16'd0, res_lo}, {16'd0, elo});
        chk({tag, ".zf"}, {31'd0, zf}, {31'd0, ezf});
        chk({tag, ".mf"}, {31'd0, mf}, {31'd0, emf});
        $display("%s: op=%b hi=%h lo=%h b=%h -> lat=%0d res=%h:%h ovf=%b zf=%b mf=%b",
                 tag, op, hi, lo, b, lat, res_hi, res_lo, ovf, zf, mf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_done;

        // Reset state
        repeat (2) @(negedge clk_sys);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.res", {res_hi, res_lo}, 32'd0);
        chk("rst.flags", {29'd0, ovf, zf, mf}, 32'd0);
        clr_ = 1'b1;
        @(negedge clk_sys);

        // -3 * 5 = -15
        run(2'b01, 16'h0000, 16'hFFFD, 16'h0005, -1);
        expect_res("smul_m3x5", EARLY ? 6 : 19, 1'b0, 16'hFFFF, 16'hFFF1, 1'b0, 1'b1);
        chk("smul_m3x5.busy_in_done", {31'd0, busy}, 32'd1);
        // start in the done cycle must be ignored
        op = 2'b00; lo = 16'h0001; b = 16'h0001; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        chk("start_in_done.busy", {31'd0, busy}, 32'd0);
        chk("start_in_done.done", {31'd0, done}, 32'd0);
        @(negedge clk_sys);
        chk("start_in_done.busy2", {31'd0, busy}, 32'd0);

        run(2'b00, 16'h0000, 16'hFFFF, 16'hFFFF, -1);
        expect_res("umul_ffff", 19, 1'b0, 16'hFFFE, 16'h0001, 1'b0, 1'b1);

        run(2'b10, 16'h0000, 16'h0064, 16'h0007, -1);
        expect_res("sdiv_100_7", 19, 1'b0, 16'h0002, 16'h000E, 1'b0, 1'b0);

        run(2'b10, 16'hFFFF, 16'hFF9C, 16'h0007, -1);
        expect_res("sdiv_m100_7", 19, 1'b0, 16'hFFFE, 16'hFFF2, 1'b0, 1'b1);

        run(2'b10, 16'h0000, 16'h0064, 16'hFFF9, -1);
        expect_res("sdiv_100_m7", 19, 1'b0, 16'h0002, 16'hFFF2, 1'b0, 1'b1);

        // Aborted divisions keep the previous results and flags
        run(2'b10, 16'h0000, 16'h0064, 16'h0000, -1);
        expect_res("sdiv_by0", 2, 1'b1, 16'h0002, 16'hFFF2, 1'b0, 1'b1);

        run(2'b10, 16'h0001, 16'h0000, 16'h0001, -1);
        expect_res("sdiv_hi_ge_b", 2, 1'b1, 16'h0002, 16'hFFF2, 1'b0, 1'b1);

        run(2'b10, 16'h0000, 16'h8000, 16'h0001, -1);
        expect_res("sdiv_pos_ovf", 19, 1'b1, 16'h0002, 16'hFFF2, 1'b0, 1'b1);

        run(2'b10, 16'hFFFF, 16'h8000, 16'h0001, -1);
        expect_res("sdiv_neg_min", 19, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b1);

        run(2'b01, 16'h0000, 16'h8000, 16'h8000, -1);
        expect_res("smul_min_min", 19, 1'b0, 16'h4000, 16'h0000, 1'b0, 1'b0);

        run(2'b11, 16'h0003, 16'h0005, 16'h0010, -1);
        expect_res("udiv_30005_10", 19, 1'b0, 16'h0005, 16'h3000, 1'b0, 1'b0);

        run(2'b00, 16'hABCD, 16'h0000, 16'h1234, -1);
        expect_res("umul_zero", EARLY ? 16 : 19, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // start pulse sampled at edge k+5 while busy must be ignored
        run(2'b00, 16'h0000, 16'h1234, 16'h8003, 4);
        expect_res("umul_poke", 19, 1'b0, 16'h091A, 16'h369C, 1'b0, 1'b0);

        // clr_ in the middle of a multiply
        @(negedge clk_sys);
        op = 2'b00; lo = 16'h1234; b = 16'h8003; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        repeat (7) @(negedge clk_sys);
        clr_ = 1'b0;
        #1;
        chk("clr_mid.busy", {31'd0, busy}, 32'd0);
        chk("clr_mid.done", {31'd0, done}, 32'd0);
        chk("clr_mid.res", {res_hi, res_lo}, 32'd0);
        chk("clr_mid.flags", {29'd0, ovf, zf, mf}, 32'd0);
        $display("clr_mid: busy=%b done=%b res=%h:%h", busy, done, res_hi, res_lo);
        @(negedge clk_sys);
        clr_ = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk_sys);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        chk("clr_mid.no_done", {31'd0, saw_done}, 32'd0);

`ifdef PA_MULDIV_EARLY_EN
        run(2'b00, 16'h0000, 16'h1234, 16'h0003, -1);
        expect_res("early_umul_x3", 5, 1'b0, 16'h0000, 16'h369C, 1'b0, 1'b0);
        run(2'b00, 16'h0000, 16'h1234, 16'h0000, -1);
        expect_res("early_umul_x0", 3, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pa_muldiv.md
Name: pa_muldiv

Overview:
- Parametrised multi-cycle multiply/divide engine for the P-A datapath. It implements the MW/DW-class arithmetic that the single-cycle ALU cannot.
- Consumes an operand pair from the AC/AT/A side and produces a 2×WIDTH product, or a quotient/remainder pair.
- Reports Z/M/overflow flags and handshakes with the control unit through start/busy/done.
- Generalises the fixed 16-bit datapath to WIDTH bits and adds iterative sequencing.

Parameters:
WIDTH, 16, operand width in bits; must be ≥4 and even.
DIV_EN, 1, 1 = division ops implemented; 0 = div ops complete immediately with ovf=1.

Ports:
clk_sys  in  1  system clock
clr_  in  1  asynchronous active-low reset
start  in  1  request; sampled on rising clk_sys while idle
op  in  2  00 unsigned mul, 01 signed mul, 10 signed div, 11 unsigned div
hi  in  WIDTH  dividend high word (div); ignored for mul
lo  in  WIDTH  multiplicand (mul) / dividend low word (div)
b  in  WIDTH  multiplier (mul) / divisor (div)
busy  out  1  operation in progress
done  out  1  one-cycle pulse: results valid
res_hi  out  WIDTH  product high word / remainder
res_lo  out  WIDTH  product low word / quotient
ovf  out  1  division overflow or divide-by-zero
zf  out  1  result zero (mul: all 2W bits; div: quotient)
mf  out  1  result sign (mul: res_hi MSB; div: quotient MSB)

Behaviour:
- Reset (clr_=0, async): state IDLE; busy=0, done=0, ovf=0, zf=0, mf=0, res_hi=res_lo=0; iteration counter=0.
- States: IDLE, PRE, ITER, FIX, DONE.
- IDLE:
  - start=1 at edge k latches op, hi, lo, b and goes to PRE.
  - busy=1 from k+1 until DONE is left.
- PRE (1 cycle):
  - Signed ops take operand magnitudes and record the result sign and the remainder sign (= dividend sign).
  - Div with b=0 goes to DONE with ovf=1.
  - Div with |hi| ≥ |b| goes to DONE with ovf=1.
  - Otherwise go to ITER with counter=WIDTH-1.
- ITER (WIDTH cycles, one bit per cycle):
  - Mul: shift-add into a 2W accumulator.
  - Div: restoring shift-subtract; quotient bit = no-borrow.
  - Counter decrements; exit to FIX when counter=0.
- FIX (1 cycle):
  - Negate the product/quotient if the result sign is 1; negate the remainder if the dividend sign is 1.
  - Signed div sets ovf when the quotient magnitude exceeds 2^(W-1)-1 (positive) or 2^(W-1) (negative).
  - Go to DONE.
- DONE (1 cycle):
  - done=1; res_*, zf, mf, ovf update this cycle and hold until the next accepted start.
  - busy=0 in the cycle after done.
- Latency: start at edge k → done high in cycle k+WIDTH+3 for all non-aborted ops; div-by-zero/early overflow → done at k+2.
- On ovf: res_hi/res_lo keep their previous values; zf/mf unchanged.
- start while busy: ignored, no queuing.
- start in the same cycle as done: ignored; start is accepted only from IDLE.
- clr_ mid-operation: immediate return to reset values; partial result discarded.
- Arithmetic is pure 2's complement.
  - Signed mul of -2^(W-1) × -2^(W-1) = +2^(2W-2) is exact and never sets ovf.
  - Mul never sets ovf.
- Results written with ovf=0 are always fully computed; no intermediate values appear on res_*.

Optional Feature:
- Macro: PA_MULDIV_EARLY_EN.
- Defined:
  - Mul exits ITER to FIX as soon as the remaining unshifted multiplier bits are all zero; the accumulator is aligned by the residual shift count in FIX.
  - Minimum mul latency is k+3 (b=0).
  - Division latency is unchanged.
- Undefined: fixed latency as above.

Test Plan:
- WIDTH=16, op=01, lo=0xFFFD (-3), b=0x0005 → done at k+19, res_hi=0xFFFF, res_lo=0xFFF1, zf=0, mf=1, ovf=0.
- op=00, lo=0xFFFF, b=0xFFFF → res_hi=0xFFFE, res_lo=0x0001, mf=1.
- op=10, hi:lo=0x0000:0x0064, b=7 → res_lo=0x000E, res_hi=0x0002. Repeat with hi:lo=0xFFFF:0xFF9C (-100) → res_lo=0xFFF2, res_hi=0xFFFE, mf=1.
- op=10, b=0 → done at k+2, ovf=1, res_* unchanged. Separately, op=10, hi:lo=0x0001:0x0000, b=1 → ovf=1 at k+2.
- Pulse start again at k+5 during a mul → ignored, result unchanged. Pulse clr_ low at k+8 → busy=0 immediately, res_*=0, no done.
- With PA_MULDIV_EARLY_EN: op=00, lo=0x1234, b=0x0003 → correct product 0x0000:0x369C, done earlier than k+19; b=0 → done at k+3, zf=1.
